// File: rtl/xyf_sign_cmp_pkg.sv
// xyf_sign_cmp_pkg
// Shared definitions for the registered signed/unsigned magnitude comparator:
//   - default operand width
//   - compare-mode constants (two's complement vs unsigned)
//   - packed flag struct carried from the compare core to the output register
//   - helper that builds a consistent flag set from "greater" and "equal"
package xyf_sign_cmp_pkg;

  localparam int unsigned XYF_DEF_WIDTH      = 8;
  localparam int unsigned XYF_MODE_UNSIGNED  = 0;
  localparam int unsigned XYF_MODE_SIGNED    = 1;

  typedef struct packed {
    logic ageb;
    logic agtb;
    logic aeqb;
  } xyf_flags_t;

  // AGEB is always derived from the other two, so the invariants
  // (AGTB -> AGEB, AEQB -> AGEB) hold by construction.
  function automatic xyf_flags_t xyf_make_flags(input logic gt, input logic eq);
    xyf_flags_t f;
    f.agtb = gt;
    f.aeqb = eq;
    f.ageb = gt | eq;
    return f;
  endfunction

endpackage

// File: rtl/xyf_sign_cmp_cmp_core.sv
// xyf_cmp_core
// Purely combinational magnitude compare of two WIDTH-bit operands.
// In signed mode the MSB of each operand is inverted, which maps the
// two's-complement range monotonically onto the unsigned range, so a single
// unsigned compare serves both modes.
// Ports:
//   a_i      operand A
//   b_i      operand B
//   flags_o  {ageb, agtb, aeqb}
module xyf_cmp_core
  import xyf_sign_cmp_pkg::*;
#(
  parameter int unsigned WIDTH  = XYF_DEF_WIDTH,
  parameter int unsigned SIGNED = XYF_MODE_SIGNED
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output xyf_flags_t       flags_o
);

  logic [WIDTH-1:0] msb_mask;
  logic [WIDTH-1:0] a_biased;
  logic [WIDTH-1:0] b_biased;
  logic             gt;
  logic             eq;

  always_comb begin
    msb_mask            = '0;
    msb_mask[WIDTH-1]   = (SIGNED != XYF_MODE_UNSIGNED);
  end

  assign a_biased = a_i ^ msb_mask;
  assign b_biased = b_i ^ msb_mask;

  // Equality is unaffected by the bias, so compare the raw operands.
  assign gt = (a_biased > b_biased);
  assign eq = (a_i == b_i);

  assign flags_o = xyf_make_flags(gt, eq);

endmodule

// File: rtl/xyf_sign_cmp.sv
// xyf_sign_cmp
// Registered magnitude comparator. Flags load from the compare core when
// IN_VALID is high and hold otherwise; OUT_VALID is a registered copy of
// IN_VALID. All state clears asynchronously on NSYSRESET low.
// Ports:
//   SYSCLK     system clock, rising edge
//   NSYSRESET  asynchronous active-low reset
//   DataA      operand A
//   DataB      operand B
//   IN_VALID   operands valid this cycle
//   AGEB       registered A >= B
//   AGTB       registered A >  B
//   AEQB       registered A == B
//   OUT_VALID  registered IN_VALID, qualifies the flags
module xyf_sign_cmp
  import xyf_sign_cmp_pkg::*;
#(
  parameter int unsigned WIDTH  = XYF_DEF_WIDTH,
  parameter int unsigned SIGNED = XYF_MODE_SIGNED
) (
  input  logic             SYSCLK,
  input  logic             NSYSRESET,
  input  logic [WIDTH-1:0] DataA,
  input  logic [WIDTH-1:0] DataB,
  input  logic             IN_VALID,
  output logic             AGEB,
  output logic             AGTB,
  output logic             AEQB,
  output logic             OUT_VALID
);

  xyf_flags_t cmp_flags;
  xyf_flags_t flags_d;
  xyf_flags_t flags_q;
  logic       valid_d;
  logic       valid_q;

  xyf_cmp_core #(
    .WIDTH  (WIDTH),
    .SIGNED (SIGNED)
  ) u_core (
    .a_i     (DataA),
    .b_i     (DataB),
    .flags_o (cmp_flags)
  );

  // The valid path never sees the operands, so X data cannot reach OUT_VALID.
  always_comb begin
    flags_d = flags_q;
    valid_d = IN_VALID;
    if (IN_VALID) begin
      flags_d = cmp_flags;
    end
  end

  always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
    if (!NSYSRESET) begin
      flags_q <= '0;
      valid_q <= 1'b0;
    end else begin
      flags_q <= flags_d;
      valid_q <= valid_d;
    end
  end

  assign AGEB      = flags_q.ageb;
  assign AGTB      = flags_q.agtb;
  assign AEQB      = flags_q.aeqb;
  assign OUT_VALID = valid_q;

endmodule

// File: tb/tb_xyf_sign_cmp.sv
module tb_xyf_sign_cmp;

  logic       clk;
  logic       rst_n;
  logic [7:0] data_a;
  logic [7:0] data_b;
  logic       in_valid;

  logic ageb_s, agtb_s, aeqb_s, ov_s;
  logic ageb_u, agtb_u, aeqb_u, ov_u;

  int unsigned errors;
  int unsigned total;

  // Scoreboard entries are {ageb, agtb, aeqb, out_valid}.
  logic [3:0] sb_s[$];
  logic [3:0] sb_u[$];
  logic [2:0] held_s;
  logic [2:0] held_u;

  xyf_sign_cmp #(
    .WIDTH  (8),
    .SIGNED (1)
  ) dut_s (
    .SYSCLK    (clk),
    .NSYSRESET (rst_n),
    .DataA     (data_a),
    .DataB     (data_b),
    .IN_VALID  (in_valid),
    .AGEB      (ageb_s),
    .AGTB      (agtb_s),
    .AEQB      (aeqb_s),
    .OUT_VALID (ov_s)
  );

  xyf_sign_cmp #(
    .WIDTH  (8),
    .SIGNED (0)
  ) dut_u (
    .SYSCLK    (clk),
    .NSYSRESET (rst_n),
    .DataA     (data_a),
    .DataB     (data_b),
    .IN_VALID  (in_valid),
    .AGEB      (ageb_u),
    .AGTB      (agtb_u),
    .AEQB      (aeqb_u),
    .OUT_VALID (ov_u)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s a=%h b=%h observed=%b expected=%b", tag, data_a, data_b, obs, exp);
    end
  endtask

  task automatic check_inv(input string tag, input logic [3:0] obs);
    logic ok;
    ok = !obs[0] || ((!obs[2] || obs[3]) && (!obs[1] || obs[3]) && !(obs[2] && obs[1]));
    total++;
    assert (ok === 1'b1) else begin
      errors++;
      $error("FAIL %s a=%h b=%h observed=%b expected=invariants_hold", tag, data_a, data_b, obs);
    end
  endtask

  // Drive one cycle of stimulus, push expectations, then compare after the edge.
  task automatic step(input logic [7:0] a, input logic [7:0] b, input logic v,
                      input logic [2:0] exp_s, input logic [2:0] exp_u, input string tag);
    logic [3:0] obs;
    data_a   = a;
    data_b   = b;
    in_valid = v;
    if (v) begin
      held_s = exp_s;
      held_u = exp_u;
    end
    sb_s.push_back({held_s, v});
    sb_u.push_back({held_u, v});
    @(posedge clk);
    #1;
    obs = {ageb_s, agtb_s, aeqb_s, ov_s};
    check({tag, "_s"}, obs, sb_s.pop_front());
    check_inv({tag, "_s_inv"}, obs);
    obs = {ageb_u, agtb_u, aeqb_u, ov_u};
    check({tag, "_u"}, obs, sb_u.pop_front());
    check_inv({tag, "_u_inv"}, obs);
  endtask

  function automatic logic [2:0] ref_signed(input logic [7:0] a, input logic [7:0] b);
    int sa;
    int sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    return {sa >= sb, sa > sb, sa == sb};
  endfunction

  function automatic logic [2:0] ref_unsigned(input logic [7:0] a, input logic [7:0] b);
    int unsigned ua;
    int unsigned ub;
    ua = a;
    ub = b;
    return {ua >= ub, ua > ub, ua == ub};
  endfunction

  initial begin
    errors   = 0;
    total    = 0;
    held_s   = '0;
    held_u   = '0;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    data_a   = 8'h00;
    data_b   = 8'h00;

    // Reset held for 10 cycles with valid operands present.
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("reset_hold_s", {ageb_s, agtb_s, aeqb_s, ov_s}, 4'b0000);
      check("reset_hold_u", {ageb_u, agtb_u, aeqb_u, ov_u}, 4'b0000);
    end
    #20 rst_n = 1'b1;

    step(8'h00, 8'h00, 1'b1, 3'b101, 3'b101, "first_after_reset");
    step(8'h7F, 8'h80, 1'b1, 3'b110, 3'b000, "max_vs_min");
    step(8'h80, 8'h7F, 1'b1, 3'b000, 3'b110, "min_vs_max");
    step(8'hFF, 8'h00, 1'b1, 3'b000, 3'b110, "neg1_vs_0");
    step(8'h00, 8'hFF, 1'b1, 3'b110, 3'b000, "0_vs_neg1");
    step(8'h80, 8'h80, 1'b1, 3'b101, 3'b101, "eq_min");
    step(8'h7F, 8'h7F, 1'b1, 3'b101, 3'b101, "eq_max");
    step(8'h05, 8'h03, 1'b1, 3'b110, 3'b110, "load_5_3");
    step(8'h01, 8'h09, 1'b0, 3'b000, 3'b000, "hold_invalid");

    // Reset pulse between edges must clear outputs without a clock.
    #20 rst_n = 1'b0;
    #5;
    check("async_reset_s", {ageb_s, agtb_s, aeqb_s, ov_s}, 4'b0000);
    check("async_reset_u", {ageb_u, agtb_u, aeqb_u, ov_u}, 4'b0000);
    #5 rst_n = 1'b1;
    held_s = '0;
    held_u = '0;

    step(8'h05, 8'h03, 1'b0, 3'b000, 3'b000, "hold_after_reset");
    step(8'h05, 8'h03, 1'b1, 3'b110, 3'b110, "reload_5_3");

    // Exhaustive sweep, back-to-back valid operands.
    for (int i = 0; i < 65536; i++) begin
      logic [15:0] pair;
      pair = i[15:0];
      step(pair[15:8], pair[7:0], 1'b1,
           ref_signed(pair[15:8], pair[7:0]),
           ref_unsigned(pair[15:8], pair[7:0]), "sweep");
    end

    step(8'h00, 8'h01, 1'b0, ref_signed(8'hFF, 8'hFF), ref_unsigned(8'hFF, 8'hFF), "final_hold");

    $display("Result: errors=%0d of %0d checks", errors, total);
    $finish;
  end

endmodule
